// File: rtl/spike_aer_pkg.sv
// Shared types and helpers for the spike-to-AER encoder: neuron/stamp widths,
// scanner state, event layout and the lowest-set-bit priority encoder.
package spike_aer_pkg;

  // Neuron count and stamp width are fixed for the whole neuron-array build.
  localparam int N_NEURONS = 8;
  localparam int TS_W      = 8;
  localparam int ADDR_W    = $clog2(N_NEURONS);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } scan_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [TS_W-1:0]   ts;
  } aer_event_t;

  // Scanning from the top down leaves the lowest set index as the result.
  function automatic logic [ADDR_W-1:0] lowest_set_idx(input logic [N_NEURONS-1:0] vec);
    lowest_set_idx = '0;
    for (int i = N_NEURONS - 1; i >= 0; i--) begin
      if (vec[i]) lowest_set_idx = ADDR_W'(i);
    end
  endfunction

endpackage

// File: rtl/aer_sync_fifo.sv
// First-word fall-through synchronous FIFO for address events; the head
// output reads as zero whenever the FIFO is empty.
module aer_sync_fifo #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         din_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q, wr_d;
  logic [AW:0]      rd_q, rd_d;
  logic             do_push;
  logic             do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign level_o = wr_q - rd_q;

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  assign wr_d = wr_q + (AW + 1)'(do_push);
  assign rd_d = rd_q + (AW + 1)'(do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= din_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  assign dout_o = empty_o ? '0 : mem_q[rd_q[AW-1:0]];

endmodule

// File: rtl/spike_aer_encoder.sv
// Serialises each timestep's spike vector into AER events on a valid/ready
// stream. Define SPIKE_AER_TIMESTAMP_EN to carry the timestep stamp in aer_ts.
module spike_aer_encoder
  import spike_aer_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [N_NEURONS-1:0]          spike,
  input  logic                          spike_valid,
  output logic                          aer_valid,
  input  logic                          aer_ready,
  output logic [ADDR_W-1:0]             aer_addr,
  output logic [TS_W-1:0]               aer_ts,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic [7:0]                    drop_cnt
);

`ifdef SPIKE_AER_TIMESTAMP_EN
  localparam int ENTRY_W = $bits(aer_event_t);
`else
  localparam int ENTRY_W = ADDR_W;
`endif

  scan_state_e          state_q, state_d;
  logic [N_NEURONS-1:0] pending_q, pending_d;
  logic                 overflow_q, overflow_d;
  logic [7:0]           drop_cnt_q, drop_cnt_d;

  logic [N_NEURONS-1:0] pending_rest;
  logic                 accept;
  logic                 fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [ENTRY_W-1:0]   push_data, head_data;

  assign fifo_pop     = !fifo_empty && aer_ready;
  assign pending_rest = pending_q & (pending_q - 1'b1);

  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    fifo_push  = 1'b0;
    accept     = 1'b0;
    case (state_q)
      IDLE: accept = spike_valid;
      SCAN: begin
        if (!fifo_full || fifo_pop) begin
          fifo_push = 1'b1;
          pending_d = pending_rest;
          // A new vector may land on the final push so scans run back to back.
          if (pending_rest == '0) begin
            state_d = IDLE;
            accept  = spike_valid;
          end
        end
        if (spike_valid && !accept) begin
          overflow_d = 1'b1;
          if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (accept && (spike != '0)) begin
      pending_d = spike;
      state_d   = SCAN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pending_q  <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

`ifdef SPIKE_AER_TIMESTAMP_EN
  logic [TS_W-1:0] ts_cnt_q, ts_cnt_d;
  logic [TS_W-1:0] cur_ts_q, cur_ts_d;
  aer_event_t      push_evt, head_evt;

  // Dropped vectors still advance the stamp so it tracks real time.
  assign ts_cnt_d = ts_cnt_q + TS_W'(spike_valid);
  assign cur_ts_d = (accept && (spike != '0)) ? ts_cnt_q : cur_ts_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_cnt_q <= '0;
      cur_ts_q <= '0;
    end else begin
      ts_cnt_q <= ts_cnt_d;
      cur_ts_q <= cur_ts_d;
    end
  end

  assign push_evt.addr = lowest_set_idx(pending_q);
  assign push_evt.ts   = cur_ts_q;
  assign push_data     = push_evt;
  assign head_evt      = head_data;
  assign aer_addr      = head_evt.addr;
  assign aer_ts        = head_evt.ts;
`else
  assign push_data = lowest_set_idx(pending_q);
  assign aer_addr  = head_data;
  assign aer_ts    = '0;
`endif

  aer_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (fifo_push),
    .din_i   (push_data),
    .pop_i   (fifo_pop),
    .dout_o  (head_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  assign aer_valid = !fifo_empty;
  assign overflow  = overflow_q;
  assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_spike_aer_encoder.sv
// Scoreboard bench for spike_aer_encoder: a count-level model predicts events,
// occupancy and drops; a negedge monitor compares the stream as it appears.
module tb_spike_aer_encoder;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] spike;
  logic       spike_valid;
  logic       aer_valid;
  logic       aer_ready;
  logic [2:0] aer_addr;
  logic [7:0] aer_ts;
  logic [3:0] fifo_level;
  logic       overflow;
  logic [7:0] drop_cnt;

  spike_aer_encoder #(.FIFO_DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .spike       (spike),
    .spike_valid (spike_valid),
    .aer_valid   (aer_valid),
    .aer_ready   (aer_ready),
    .aer_addr    (aer_addr),
    .aer_ts      (aer_ts),
    .fifo_level  (fifo_level),
    .overflow    (overflow),
    .drop_cnt    (drop_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: events still to be scanned, FIFO occupancy, drop stats.
  int          m_rem   = 0;
  int          m_level = 0;
  int          m_ts    = 0;
  int          m_drop  = 0;
  bit          m_ovf   = 1'b0;
  logic [10:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_rem = 0; m_level = 0; m_ts = 0; m_drop = 0; m_ovf = 1'b0;
    exp_q.delete();
  endtask

  // Advances the model across one clock edge given the inputs held before it.
  task automatic model_step(input bit sv, input logic [7:0] sp, input bit rdy);
    bit         pop, move, acc;
    logic [7:0] ts_exp;
    pop  = (m_level > 0) && rdy;
    move = (m_rem > 0) && ((m_level < DEPTH) || pop);
    acc  = sv && ((m_rem == 0) || ((m_rem == 1) && move));
    if (move) m_rem--;
    m_level = m_level + int'(move) - int'(pop);
`ifdef SPIKE_AER_TIMESTAMP_EN
    ts_exp = 8'(m_ts);
`else
    ts_exp = 8'h00;
`endif
    if (acc) begin
      m_rem = $countones(sp);
      for (int i = 0; i < 8; i++) begin
        if (sp[i]) exp_q.push_back({3'(i), ts_exp});
      end
    end else if (sv) begin
      m_ovf = 1'b1;
      if (m_drop < 255) m_drop++;
    end
    if (sv) m_ts = (m_ts + 1) % 256;
  endtask

  task automatic step(input bit sv, input logic [7:0] sp, input bit rdy);
    spike_valid = sv;
    spike       = sp;
    aer_ready   = rdy;
    @(posedge clk);
    #1;
    model_step(sv, sp, rdy);
  endtask

  // Monitor: status vs model every cycle, head event vs scoreboard on handshake.
  bit         hold_v = 1'b0;
  logic [2:0] hold_a;
  logic [7:0] hold_t;

  always @(negedge clk) begin
    if (!rst_n) begin
      hold_v = 1'b0;
    end else begin
      check("fifo_level", 32'(fifo_level), 32'(m_level));
      check("aer_valid", 32'(aer_valid), 32'(m_level > 0));
      check("overflow", 32'(overflow), 32'(m_ovf));
      check("drop_cnt", 32'(drop_cnt), 32'(m_drop));
      if (hold_v && aer_valid) begin
        check("stable_addr", 32'(aer_addr), 32'(hold_a));
        check("stable_ts", 32'(aer_ts), 32'(hold_t));
      end
      if (aer_valid && aer_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_event: got addr %0d ts %0d, expected no event", aer_addr, aer_ts);
        end else begin
          logic [10:0] e;
          e = exp_q.pop_front();
          check("event_addr", 32'(aer_addr), 32'(e[10:8]));
          check("event_ts", 32'(aer_ts), 32'(e[7:0]));
          $display("[TB] event addr=%0d ts=%0d", aer_addr, aer_ts);
        end
      end
      hold_v = aer_valid && !aer_ready;
      hold_a = aer_addr;
      hold_t = aer_ts;
    end
  end

  initial begin
    rst_n = 1'b0; spike = '0; spike_valid = 1'b0; aer_ready = 1'b0;
    #1;
    check("rst_valid", 32'(aer_valid), 0);
    check("rst_addr", 32'(aer_addr), 0);
    check("rst_ts", 32'(aer_ts), 0);
    check("rst_level", 32'(fifo_level), 0);
    check("rst_overflow", 32'(overflow), 0);
    check("rst_drop", 32'(drop_cnt), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Basic vector: events 0,5,7.
    step(1'b1, 8'hA1, 1'b1);
    repeat (6) step(1'b0, 8'h00, 1'b1);

    // Empty timesteps advance the stamp.
    repeat (3) step(1'b1, 8'h00, 1'b1);
    step(1'b1, 8'h04, 1'b1);
    repeat (4) step(1'b0, 8'h00, 1'b1);

    // New vector on the final push is accepted without a drop.
    step(1'b1, 8'h03, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    step(1'b1, 8'h80, 1'b1);
    repeat (5) step(1'b0, 8'h00, 1'b1);
    check("no_drop_overflow", 32'(overflow), 0);

    // Backpressure: FIFO fills to depth, scanner stalls, then drains.
    step(1'b1, 8'hFF, 1'b0);
    repeat (10) step(1'b0, 8'h00, 1'b0);
    check("full_level", 32'(fifo_level), DEPTH);
    repeat (10) step(1'b0, 8'h00, 1'b1);

    // Mid-scan strobe is dropped.
    step(1'b1, 8'hFF, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    step(1'b1, 8'h3C, 1'b1);
    repeat (10) step(1'b0, 8'h00, 1'b1);
    step(1'b1, 8'h10, 1'b1);
    repeat (4) step(1'b0, 8'h00, 1'b1);
    check("drop_overflow", 32'(overflow), 1);
    check("drop_count", 32'(drop_cnt), 1);

    // Asynchronous reset mid-scan with a partially filled FIFO.
    step(1'b1, 8'hFF, 1'b0);
    repeat (4) step(1'b0, 8'h00, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(aer_valid), 0);
    check("arst_level", 32'(fifo_level), 0);
    check("arst_addr", 32'(aer_addr), 0);
    check("arst_overflow", 32'(overflow), 0);
    check("arst_drop", 32'(drop_cnt), 0);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    step(1'b1, 8'h06, 1'b1);
    repeat (5) step(1'b0, 8'h00, 1'b1);

    // Randomised traffic with random backpressure.
    for (int n = 0; n < 400; n++) begin
      logic [7:0] sp;
      sp = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      step($urandom_range(0, 3) == 0, sp, $urandom_range(0, 3) != 0);
    end

    begin
      int k;
      k = 0;
      while (((m_rem > 0) || (m_level > 0)) && (k < 100)) begin
        step(1'b0, 8'h00, 1'b1);
        k++;
      end
      check("drain_timeout", 32'(k < 100), 1);
    end
    step(1'b0, 8'h00, 1'b1);
    check("scoreboard_empty", 32'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
